seq_detect_moore: RTL and testbench

SEQ_DETECT_MOORE -- requirements
Module: seq_detect_moore

---
 rtl/seq_detect_pkg.sv | 52 +++++
 rtl/seq_detect_moore_sat_counter.sv | 40 ++++
 rtl/seq_detect_moore.sv | 74 +++++++
 tb/tb_seq_detect_moore.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared constants and elaboration-time helpers for the Moore sequence detector.
package seq_detect_pkg;

    localparam int unsigned MAX_PAT_LEN = 16;

    // Width of a state register holding values 0..pat_len.
    function automatic int unsigned state_width(input int unsigned pat_len);
        return $clog2(pat_len + 1);
    endfunction

    // i-th received bit of the pattern (i = 0 is the first bit on the wire).
    function automatic logic pat_bit(input logic [MAX_PAT_LEN-1:0] pat,
                                     input int unsigned len,
                                     input int unsigned i);
        return 1'(pat >> (len - 1 - i));
    endfunction

    // Longest proper prefix of the first k pattern bits that is also a suffix of them.
    function automatic int unsigned fail_of(input logic [MAX_PAT_LEN-1:0] pat,
                                            input int unsigned len,
                                            input int unsigned k);
        logic ok;
        if (k <= 1) return 0;
        for (int unsigned l = k - 1; l >= 1; l--) begin
            ok = 1'b1;
            for (int unsigned j = 0; j < l; j++) begin
                if (pat_bit(pat, len, j) != pat_bit(pat, len, k - l + j)) ok = 1'b0;
            end
            if (ok) return l;
        end
        return 0;
    endfunction

    // Next state after receiving bit b in state k; a full match restarts from
    // its failure value when overlapping, from zero otherwise.
    function automatic int unsigned next_state(input logic [MAX_PAT_LEN-1:0] pat,
                                               input int unsigned len,
                                               input bit overlap,
                                               input int unsigned k,
                                               input logic b);
        int unsigned s;
        s = k;
        if (s == len) s = overlap ? fail_of(pat, len, len) : 0;
        for (int unsigned it = 0; it <= MAX_PAT_LEN; it++) begin
            if (pat_bit(pat, len, s) == b) return s + 1;
            if (s == 0) return 0;
            s = fail_of(pat, len, s);
        end
        return 0;
    endfunction

endpackage

// File: rtl/seq_detect_moore_sat_counter.sv
// Saturating up-counter with synchronous clear and a registered saturation flag.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         sat_q;

    // Next count: clear wins, otherwise increment until all ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count and saturation flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= &cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign sat = sat_q;

endmodule

// File: rtl/seq_detect_moore.sv
// Moore serial pattern detector with KMP transitions and a saturating match count.
module seq_detect_moore
    import seq_detect_pkg::*;
#(
    parameter int unsigned            PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0]     PATTERN = 4'b1011,
    parameter bit                     OVERLAP = 1'b0,
    parameter int unsigned            CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             in,
    output logic             det,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int unsigned               SW      = state_width(PAT_LEN);
    localparam logic [MAX_PAT_LEN-1:0]    PAT_EXT = MAX_PAT_LEN'(PATTERN);

    logic [SW-1:0] st_q, st_d;
    logic [SW-1:0] st_nxt_c;
    logic          inc_c;
    logic [SW-1:0] nxt0 [PAT_LEN+1];
    logic [SW-1:0] nxt1 [PAT_LEN+1];

    // Constant transition table, folded at elaboration.
    for (genvar k = 0; k <= PAT_LEN; k++) begin : g_nxt
        assign nxt0[k] = SW'(next_state(PAT_EXT, PAT_LEN, OVERLAP, k, 1'b0));
        assign nxt1[k] = SW'(next_state(PAT_EXT, PAT_LEN, OVERLAP, k, 1'b1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q <= '0;
        end else begin
            st_q <= st_d;
        end
    end

    // Next state and match-count strobe; clear discards the sampled bit.
    always_comb begin
        st_nxt_c = in ? nxt1[st_q] : nxt0[st_q];
        st_d     = st_q;
        inc_c    = 1'b0;
        if (clr) begin
            st_d = '0;
        end else if (in_valid) begin
            st_d  = st_nxt_c;
            inc_c = (st_nxt_c == SW'(PAT_LEN));
        end
    end

    // Moore output decoded from the state register only.
    always_comb begin
        det = 1'b0;
        if (st_q == SW'(PAT_LEN)) det = 1'b1;
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (inc_c),
        .cnt (match_cnt),
        .sat (cnt_sat)
    );

endmodule

// File: tb/tb_seq_detect_moore.sv
// Directed bench for seq_detect_moore across several parameterisations.
module tb_seq_detect_moore;

    logic clk = 1'b0;
    logic rst, clr, in_valid, d_in;

    logic       det_d0, det_d1, det_p3o, det_p3n, det_s;
    logic [7:0] cnt_d0, cnt_d1, cnt_p3o, cnt_p3n;
    logic [1:0] cnt_s;
    logic       sat_d0, sat_d1, sat_p3o, sat_p3n, sat_s;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_detect_moore #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_d0 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in(d_in),
        .det(det_d0), .match_cnt(cnt_d0), .cnt_sat(sat_d0));
    seq_detect_moore #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_d1 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in(d_in),
        .det(det_d1), .match_cnt(cnt_d1), .cnt_sat(sat_d1));
    seq_detect_moore #(.PAT_LEN(3), .PATTERN(3'b111), .OVERLAP(1'b1), .CNT_W(8)) u_p3o (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in(d_in),
        .det(det_p3o), .match_cnt(cnt_p3o), .cnt_sat(sat_p3o));
    seq_detect_moore #(.PAT_LEN(3), .PATTERN(3'b111), .OVERLAP(1'b0), .CNT_W(8)) u_p3n (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in(d_in),
        .det(det_p3n), .match_cnt(cnt_p3n), .cnt_sat(sat_p3n));
    seq_detect_moore #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_s (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in(d_in),
        .det(det_s), .match_cnt(cnt_s), .cnt_sat(sat_s));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive away from the edge, return #1 after the edge.
    task automatic step(input logic b, input logic v, input logic c);
        @(negedge clk);
        d_in = b; in_valid = v; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; clr = 1'b0; d_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [6:0] s7, e0, e1;
        logic [4:0] e3o, e3n;
        logic [3:0] pat;

        rst = 1'b0; clr = 1'b0; in_valid = 1'b0; d_in = 1'b0;
        #12;
        chk("rst_det",  32'(det_d0), 32'd0);
        chk("rst_cnt",  32'(cnt_d0), 32'd0);
        chk("rst_sat",  32'(sat_s),  32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Stream 1011011: non-overlap vs overlap.
        s7 = 7'b1011011; e0 = 7'b0001000; e1 = 7'b0001001;
        for (int i = 6; i >= 0; i--) begin
            step(s7[i], 1'b1, 1'b0);
            chk("s7_det_novl", 32'(det_d0), 32'(e0[i]));
            chk("s7_det_ovl",  32'(det_d1), 32'(e1[i]));
        end
        chk("s7_cnt_novl", 32'(cnt_d0), 32'd1);
        chk("s7_cnt_ovl",  32'(cnt_d1), 32'd2);

        // Five 1s against pattern 111.
        do_reset();
        e3o = 5'b00111; e3n = 5'b00100;
        for (int i = 4; i >= 0; i--) begin
            step(1'b1, 1'b1, 1'b0);
            chk("p111_det_ovl",  32'(det_p3o), 32'(e3o[i]));
            chk("p111_det_novl", 32'(det_p3n), 32'(e3n[i]));
        end
        chk("p111_cnt_ovl",  32'(cnt_p3o), 32'd3);
        chk("p111_cnt_novl", 32'(cnt_p3n), 32'd1);

        // 1011 with an invalid cycle after every bit.
        do_reset();
        pat = 4'b1011;
        for (int i = 3; i >= 0; i--) begin
            step(pat[i], 1'b1, 1'b0);
            chk("gap_det_valid", 32'(det_d0), (i == 0) ? 32'd1 : 32'd0);
            step(~pat[i], 1'b0, 1'b0);
            chk("gap_det_hold", 32'(det_d0), (i == 0) ? 32'd1 : 32'd0);
            chk("gap_cnt_hold", 32'(cnt_d0), (i == 0) ? 32'd1 : 32'd0);
        end

        // Repeated pattern into a 2-bit counter.
        do_reset();
        for (int r = 0; r < 5; r++) begin
            for (int i = 3; i >= 0; i--) begin
                step(pat[i], 1'b1, 1'b0);
                chk("sat_det", 32'(det_s), (i == 0) ? 32'd1 : 32'd0);
            end
            chk("sat_cnt",  32'(cnt_s), (r >= 2) ? 32'd3 : 32'(r + 1));
            chk("sat_flag", 32'(sat_s), (r >= 2) ? 32'd1 : 32'd0);
        end
        chk("rep_cnt_novl", 32'(cnt_d0), 32'd5);

        // Synchronous clear on the bit that would complete a match.
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("clr_det", 32'(det_d0), 32'd0);
        chk("clr_cnt", 32'(cnt_d0), 32'd0);
        chk("clr_sat", 32'(sat_s),  32'd0);
        step(1'b1, 1'b1, 1'b0);
        chk("clr_after_det", 32'(det_d0), 32'd0);

        // From state 1: 0,1,1 completes a match; then 1,0,1 and an async reset.
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("pre_rst_det", 32'(det_d0), 32'd1);
        chk("pre_rst_cnt", 32'(cnt_d0), 32'd1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        #2;
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("arst_det", 32'(det_d0), 32'd0);
        chk("arst_cnt", 32'(cnt_d0), 32'd0);
        chk("arst_cnt_ovl", 32'(cnt_d1), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        chk("arst_one_det", 32'(det_d0), 32'd0);
        for (int i = 3; i >= 0; i--) begin
            step(pat[i], 1'b1, 1'b0);
            chk("arst_full_det", 32'(det_d0), (i == 0) ? 32'd1 : 32'd0);
        end
        chk("arst_full_cnt", 32'(cnt_d0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
